// File: rtl/dac_playback_ctrl.sv
// Waveform playback sequencer: streams a preloaded sample RAM to the DAC over AXI-stream
// for a configured pass length and loop count, with graceful stop and completion reporting.
module dac_playback_ctrl #(
  parameter int BITS  = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [AW:0]     cfg_len,
  input  logic [15:0]     cfg_loops,
  input  logic            start,
  input  logic            stop,
  output logic [BITS-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            err
);

  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [BITS-1:0] mem [DEPTH];
  logic signed [BITS-1:0] data_p1, data_p2;
  logic                   vld_p1, vld_p2;

  logic [AW-1:0] rd_addr;
  logic [15:0]   loop_cnt, loops_q;
  logic [AW:0]   len_q;
  logic          abort_q;

  logic cfg_ok, discard, s2_load, rd_issue, last_addr, last_pass, fin, go;

  assign busy          = (state != IDLE);
  assign m_axis_tvalid = vld_p2;
  // Midscale whenever nothing is presented, so IDLE always drives zero.
  assign m_axis_tdata  = vld_p2 ? data_p2 : '0;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    rd_issue  = 1'b0;
    fin       = 1'b0;
    cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    discard   = busy && (stop || abort_q);
    s2_load   = vld_p1 && !discard && (!vld_p2 || m_axis_tready);
    last_addr = ({1'b0, rd_addr} == (len_q - LEN_ONE));
    last_pass = (loops_q != 16'd0) && (loop_cnt == (loops_q - 16'd1));
    case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          go        = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!discard) begin
          rd_issue = !vld_p1 || s2_load;
          if (rd_issue && last_addr && last_pass) state_nxt = DRAIN;
        end
      end
      default: ;
    endcase
    // An abort throws away S1 but must still let a presented S2 beat be accepted.
    if (busy && (discard || state == DRAIN)) begin
      fin       = (!vld_p1 || discard) && (!vld_p2 || m_axis_tready);
      state_nxt = fin ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      rd_addr  <= '0;
      loop_cnt <= '0;
      len_q    <= '0;
      loops_q  <= '0;
      abort_q  <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (go) begin
        rd_addr  <= '0;
        loop_cnt <= '0;
        len_q    <= cfg_len;
        loops_q  <= cfg_loops;
        abort_q  <= 1'b0;
      end else if (rd_issue) begin
        if (last_addr) begin
          rd_addr  <= '0;
          loop_cnt <= loop_cnt + 16'd1;
        end else begin
          rd_addr  <= rd_addr + ADDR_ONE;
        end
      end
      if (busy && stop) abort_q <= 1'b1;

      // S1: RAM read stage valid
      if (discard)       vld_p1 <= 1'b0;
      else if (rd_issue) vld_p1 <= 1'b1;
      else if (s2_load)  vld_p1 <= 1'b0;

      // S2: output register valid
      if (s2_load)            vld_p2 <= 1'b1;
      else if (m_axis_tready) vld_p2 <= 1'b0;

      done    <= fin;
      aborted <= fin && discard;
      err     <= (!busy && start && !cfg_ok) || (busy && wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    // S1: synchronous read, output holds when no read is issued
    if (rd_issue) data_p1 <= mem[rd_addr];
    // S2: output register
    if (s2_load) data_p2 <= data_p1;
  end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl: table-driven start checks, directed corner
// sequences, and randomized playbacks compared against an expected-beat-sequence model.
module tb_dac_playback_ctrl;
  localparam int BITS  = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [BITS-1:0] wr_data = '0;
  logic [AW:0]     cfg_len = '0;
  logic [15:0]     cfg_loops = '0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            m_axis_tready = 1'b1;
  logic [BITS-1:0] m_axis_tdata;
  logic            m_axis_tvalid;
  logic            busy, done, aborted, err;

  dac_playback_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_loops(cfg_loops), .start(start), .stop(stop),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] ram_model [DEPTH];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  int          cyc = 0;
  int          last_hs_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  typedef struct {
    int len;
    bit stp;
    bit exp_err;
    bit exp_busy;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Beat capture plus AXI-stream hold rule: a stalled beat must stay valid and unchanged.
  always @(posedge clk) begin
    cyc++;
    if (rstn && prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev_data);
    end
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(m_axis_tdata);
      last_hs_cyc = cyc;
    end
    prev_stall = rstn && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
    ram_model[a] = d;
  endtask

  function automatic void build_exp(input int len, input int loops);
    exp_q.delete();
    for (int p = 0; p < loops; p++)
      for (int a = 0; a < len; a++) exp_q.push_back(ram_model[a]);
  endfunction

  task automatic cmp_beats(input string name, input int n, input bit cnt_chk);
    int bad;
    bad = -1;
    if (cnt_chk) chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0) $display("  %s beat %0d: got %0h expected %0h", name, bad, got_q[bad], exp_q[bad]);
    chk({name, "_first_bad_beat"}, bad, -1);
  endtask

  // mode 0: tready=1, mode 1: random tready, mode 2: fixed pattern once tvalid is up
  task automatic run_play(input int len, input int loops, input int mode, input int stop_at,
                          input int budget, output bit gd, output bit ga, output int ns,
                          output int dcyc);
    got_q.delete();
    gd = 1'b0; ga = 1'b0; ns = -1; dcyc = -1;
    cfg_len = len[AW:0]; cfg_loops = loops[15:0]; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        gd = 1'b1; ga = aborted; dcyc = cyc;
        break;
      end
      case (mode)
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        2:       m_axis_tready = (c >= 2 && c - 2 < 7) ? pat[c-2] : 1'b1;
        default: m_axis_tready = 1'b1;
      endcase
      stop = (c == stop_at) && busy;
      if (stop) ns = got_q.size();
      tick();
      stop = 1'b0;
    end
    m_axis_tready = 1'b1;
  endtask

  initial begin
    bit gd, ga;
    int ns, dcyc, len, loops, stop_at, c;
    logic [15:0] held, rv;

    vecs[0] = '{0,    1'b0, 1'b1, 1'b0};
    vecs[1] = '{1025, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2047, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1,    1'b0, 1'b0, 1'b1};
    vecs[4] = '{1024, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{7,    1'b0, 1'b0, 1'b1};
    vecs[6] = '{5,    1'b1, 1'b0, 1'b1};

    do_reset();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_err", err, 0);

    // start validation table (start+stop together in IDLE: start wins)
    for (int i = 0; i < 7; i++) begin
      cfg_len = vecs[i].len[AW:0]; cfg_loops = 16'd1;
      start = 1'b1; stop = vecs[i].stp;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("tbl_err", err, vecs[i].exp_err);
      chk("tbl_busy", busy, vecs[i].exp_busy);
      tick();
      chk("tbl_err_pulse", err, 0);
      do_reset();
    end

    wr(0, 16'h0000); wr(1, 16'h5A82); wr(2, 16'h7FFF); wr(3, 16'h8001);

    // 4 samples x 2 loops, continuous tready: exact latency and gapless stream
    build_exp(4, 2);
    m_axis_tready = 1'b1; cfg_len = 11'd4; cfg_loops = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_tvalid_n0", m_axis_tvalid, 0);
    tick();
    chk("t1_tvalid_n1", m_axis_tvalid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_tvalid", m_axis_tvalid, 1);
      chk("t1_tdata", m_axis_tdata, exp_q[i]);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_aborted", aborted, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_tvalid_end", m_axis_tvalid, 0);
    chk("t1_tdata_end", m_axis_tdata, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // backpressure pattern 1,0,0,1,0,1,1
    run_play(4, 1, 2, -1, 200, gd, ga, ns, dcyc);
    chk("t2_done", gd, 1);
    chk("t2_aborted", ga, 0);
    build_exp(4, 1);
    cmp_beats("t2", 4, 1'b1);
    chk("t2_done_after_last_hs", dcyc, last_hs_cyc);

    // infinite loop, stop while stalled
    got_q.delete();
    cfg_len = 11'd3; cfg_loops = 16'd0; m_axis_tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 100 && got_q.size() < 10; c++) tick();
    chk("t3_reach_10", got_q.size(), 10);
    held = m_axis_tdata;
    stop = 1'b1; m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_held_valid", m_axis_tvalid, 1);
      chk("t3_held_data", m_axis_tdata, held);
    end
    stop = 1'b0; m_axis_tready = 1'b1;
    for (c = 0; c < 20 && !done; c++) tick();
    chk("t3_done", done, 1);
    chk("t3_aborted", aborted, 1);
    build_exp(3, 4);
    cmp_beats("t3", 11, 1'b1);
    tick(); tick();
    chk("t3_no_more_beats", got_q.size(), 11);
    chk("t3_idle_tvalid", m_axis_tvalid, 0);

    // rejected write while busy, ignored start while busy
    got_q.delete();
    cfg_len = 11'd4; cfg_loops = 16'd1; m_axis_tready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 10'd1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    chk("t4_wr_err", err, 1);
    chk("t4_busy", busy, 1);
    cfg_len = 11'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy_start_no_err", err, 0);
    m_axis_tready = 1'b1;
    for (c = 0; c < 50 && !done; c++) tick();
    chk("t4_done", done, 1);
    build_exp(4, 1);
    cmp_beats("t4_first", 4, 1'b1);
    run_play(4, 1, 0, -1, 100, gd, ga, ns, dcyc);
    chk("t4_replay_done", gd, 1);
    cmp_beats("t4_replay", 4, 1'b1);

    // reset mid-playback
    cfg_len = 11'd4; cfg_loops = 16'd0; m_axis_tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t5_pre_tvalid", m_axis_tvalid, 1);
    rstn = 1'b0;
    tick();
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tdata", m_axis_tdata, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    rstn = 1'b1;
    tick();
    chk("t5_done_after", done, 0);
    run_play(4, 1, 0, -1, 100, gd, ga, ns, dcyc);
    chk("t5_replay_done", gd, 1);
    cmp_beats("t5_replay", 4, 1'b1);

    // full-depth ramp, single pass
    for (int a = 0; a < DEPTH; a++) wr(a, 16'(a));
    run_play(DEPTH, 1, 0, -1, 1200, gd, ga, ns, dcyc);
    chk("t6_done", gd, 1);
    chk("t6_aborted", ga, 0);
    build_exp(DEPTH, 1);
    cmp_beats("t6", DEPTH, 1'b1);
    tick(); tick();
    chk("t6_no_extra_pass", got_q.size(), DEPTH);
    chk("t6_busy", busy, 0);

    // randomized playbacks, random backpressure, occasional stop
    for (int it = 0; it < 12; it++) begin
      len     = $urandom_range(1, 12);
      loops   = $urandom_range(1, 3);
      stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
      for (int a = 0; a < len; a++) begin
        rv = 16'($urandom);
        wr(a, rv);
      end
      run_play(len, loops, 1, stop_at, 600, gd, ga, ns, dcyc);
      chk("rnd_done", gd, 1);
      build_exp(len, loops);
      if (ns >= 0) begin
        chk("rnd_aborted", ga, 1);
        chk("rnd_stop_at_most_one_more", (got_q.size() <= ns + 1) && (got_q.size() >= ns), 1);
        cmp_beats("rnd_stop_prefix", got_q.size(), 1'b0);
      end else begin
        chk("rnd_aborted", ga, 0);
        cmp_beats("rnd", len * loops, 1'b1);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_playback_ctrl.md
# dac_playback_ctrl

Waveform playback sequencer sitting directly in front of the signed 16-bit DAC. Samples are preloaded into an internal sample RAM. On `start` the block streams them to the DAC's `s_axis_tdata` input over AXI-stream, for a configured length and loop count. It owns all sequencing of the DAC datapath: start, loop wrap, graceful stop and completion reporting.

## Interface
- `BITS`, 16, sample width (two's complement, matches DAC input width)
- `DEPTH`, 1024, sample RAM entries (power of two)
- `AW`, $clog2(DEPTH), address / length width
- `clk`  in  1  single clock; all logic on its rising edge
- `rstn`  in  1  synchronous, active-low reset
- `wr_en`  in  1  sample RAM write strobe
- `wr_addr`  in  AW  write address
- `wr_data`  in  BITS  signed sample to store
- `cfg_len`  in  AW+1  samples per pass (1..DEPTH); sampled on accepted `start`
- `cfg_loops`  in  16  passes to play; 0 = infinite; sampled on accepted `start`
- `start`  in  1  begin playback (level, acted on only in IDLE)
- `stop`  in  1  graceful abort request
- `m_axis_tdata`  out  BITS  sample to DAC
- `m_axis_tvalid`  out  1  sample valid
- `m_axis_tready`  in  1  DAC accepts sample
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on return to IDLE after playback
- `aborted`  out  1  qualifies `done`: 1 = ended by `stop`, 0 = natural end
- `err`  out  1  one-cycle pulse on a rejected `start` or a rejected write

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start` with 1 <= `cfg_len` <= DEPTH. Latches `cfg_len` and `cfg_loops`, and clears the read address and loop counter.
- `start` with `cfg_len` = 0 or `cfg_len` > DEPTH: stays in IDLE and pulses `err`.
- `start` while busy is ignored; no `err`.
- Writes are accepted only in IDLE. `wr_en` while busy is dropped and pulses `err`.
- Pipeline has two stages:
  - S1: synchronous RAM read, with a data-valid flag.
  - S2: output register driving `m_axis_*`.
  - S2 loads from S1 when S1 is valid and (`!m_axis_tvalid` or `m_axis_tready`).
  - S1 issues a new read when it is empty or its data moves to S2 that cycle, and more samples remain.
  - RAM output holds while no read is issued.
- Address wraps from `cfg_len`-1 to 0 and increments the loop counter.
- Reads stop after the last sample of pass `cfg_loops`; FSM -> DRAIN. With `cfg_loops` = 0 reads never stop by count.
- DRAIN -> IDLE once S1 and S2 are both empty (last beat handshaken). Pulses `done` with `aborted` = 0.
- `stop` in RUN or DRAIN:
  - no further RAM reads; S1 contents discarded;
  - an S2 beat already presented stays stable until accepted (AXI-stream rule: `tvalid` never drops without a handshake);
  - then IDLE, with `done` = 1 and `aborted` = 1.
- `stop` in IDLE has no effect.
- `stop` and `start` together in IDLE: `start` wins.
- In IDLE `m_axis_tdata` = 0 (DAC midscale) and `m_axis_tvalid` = 0.
- `m_axis_tdata` is the stored word unmodified; no scaling, no sign handling.

## Timing
- Reset (rstn = 0 at a clk edge):
  - state IDLE; `m_axis_tdata` = 0, `m_axis_tvalid` = 0, `busy` = 0, `done` = 0, `aborted` = 0, `err` = 0;
  - S1 flushed, address and loop counter = 0;
  - RAM contents are not cleared.
- Reset mid-playback takes effect the same edge. Outputs are at reset values on the next cycle; no `done` pulse.
- Start latency: `start` sampled at edge N -> `busy` = 1 after N. First read issued in cycle N+1. First `m_axis_tvalid` = 1 after edge N+2.
- Throughput: one sample per clk while `m_axis_tready` = 1. No bubbles across a loop wrap.
- `m_axis_tready` low for k cycles stalls S2 for exactly k cycles. `m_axis_tdata` is held stable and no samples are lost or duplicated.
- `done`/`aborted` are asserted the cycle after the final handshake, for exactly one cycle.
- `err` is asserted the cycle after the offending request.
- Write to RAM is visible to a `start` issued the next cycle.

## Test plan
- Load RAM[0..3] = 0x0000, 0x5A82, 0x7FFF, 0x8001; `cfg_len` = 4, `cfg_loops` = 2, `tready` = 1; pulse `start` -> `tvalid` rises 2 cycles later. Exactly 8 beats 0,5A82,7FFF,8001,0,5A82,7FFF,8001 with no gaps. Then `done` = 1, `aborted` = 0, `busy` = 0, `tdata` = 0.
- Same load, `cfg_loops` = 1; `tready` pattern 1,0,0,1,0,1,1 -> 4 beats in order, each `tdata` stable while stalled, no duplicates. `done` after the 4th handshake.
- `cfg_len` = 3, `cfg_loops` = 0; run 10 beats, assert `stop` with `tready` = 0 for 3 cycles -> the presented beat is held, then accepted. No further beats; `done` = 1, `aborted` = 1.
- `start` with `cfg_len` = 0 -> `err` pulse, `busy` stays 0. `wr_en` during playback -> `err` pulse, and that RAM word is unchanged on a later playback.
- Reset asserted mid-playback with `tvalid` = 1 -> next cycle `tvalid` = 0, `tdata` = 0, `busy` = 0, no `done`. A subsequent `start` replays from address 0 with the RAM contents intact.
- `cfg_len` = 1024 (DEPTH), `cfg_loops` = 1, RAM loaded with a ramp (value = address) -> 1024 beats 0..1023, wrap logic not triggering an extra pass, then `done`.
